// File: rtl/seg7_pkg.sv
// Shared constants and FSM state type for the binary-to-BCD front end of the 8-digit display.
package seg7_pkg;

    localparam int          SEG7_DIGITS  = 8;
    localparam int          BCD_ACC_W    = 40;
    localparam int          BCD_DIGITS   = BCD_ACC_W / 4;
    localparam int unsigned SEG7_MAX_DEC = 99_999_999;
    localparam logic [31:0] SAT_BCD      = 32'h9999_9999;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } seg7_state_e;

endpackage

// File: rtl/seg7_bin2bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/seg7_bin2bcd.sv
// Sequential binary-to-BCD converter feeding the 8-digit seven-segment driver.
// Build option: define SEG7_LZB_EN to enable leading-zero blanking on aen.
//   state  | meaning
//   IDLE   | waiting for start; outputs hold the last result
//   SHIFT  | one add-3/shift iteration per cycle, BIN_W cycles
//   FINISH | publish x/aen/dp_en/overflow together with done
module seg7_bin2bcd
    import seg7_pkg::*;
#(
    parameter int BIN_W = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    input  logic [7:0]       dp_in,
    output logic             busy,
    output logic             done,
    output logic [31:0]      x,
    output logic [7:0]       aen,
    output logic [7:0]       dp_en,
    output logic             overflow
);

    seg7_state_e          state_q, state_d;
    logic [BIN_W-1:0]     shreg_q, shreg_d;
    logic [BCD_ACC_W-1:0] acc_q, acc_d;
    logic [5:0]           cnt_q, cnt_d;
    logic [7:0]           dp_lat_q, dp_lat_d;
    logic [31:0]          x_q, x_d;
    logic [7:0]           aen_q, aen_d;
    logic [7:0]           dp_en_q, dp_en_d;
    logic                 ovf_q, ovf_d;
    logic                 done_q, done_d;

    logic [BCD_ACC_W-1:0]       acc_adj;
    logic [BCD_ACC_W+BIN_W-1:0] shifted;
    logic                       ovf_fin;
    logic [31:0]                x_fin;
    logic [7:0]                 aen_calc;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .d (acc_q[4*g +: 4]),
            .q (acc_adj[4*g +: 4])
        );
    end

    assign shifted = {acc_adj, shreg_q} << 1;
    assign ovf_fin = |acc_q[BCD_ACC_W-1:32];
    assign x_fin   = ovf_fin ? SAT_BCD : acc_q[31:0];

`ifdef SEG7_LZB_EN
    localparam logic [7:0] AEN_RST = 8'h01;
    logic seen_nz;

    // A digit is lit if it or any more-significant digit is nonzero; digit 0 is always lit.
    always_comb begin
        aen_calc = '0;
        seen_nz  = 1'b0;
        for (int i = SEG7_DIGITS - 1; i >= 0; i--) begin
            if (x_fin[4*i +: 4] != 4'd0) seen_nz = 1'b1;
            aen_calc[i] = seen_nz;
        end
        aen_calc[0] = 1'b1;
    end
`else
    localparam logic [7:0] AEN_RST = 8'hFF;
    assign aen_calc = 8'hFF;
`endif

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        dp_lat_d = dp_lat_q;
        x_d      = x_q;
        aen_d    = aen_q;
        dp_en_d  = dp_en_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d  = bin;
                    acc_d    = '0;
                    cnt_d    = 6'(BIN_W - 1);
                    dp_lat_d = dp_in;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                acc_d   = shifted[BCD_ACC_W+BIN_W-1:BIN_W];
                shreg_d = shifted[BIN_W-1:0];
                if (cnt_q == 6'd0) state_d = FINISH;
                else               cnt_d   = cnt_q - 6'd1;
            end
            FINISH: begin
                ovf_d   = ovf_fin;
                x_d     = x_fin;
                aen_d   = aen_calc;
                dp_en_d = dp_lat_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            dp_lat_q <= '0;
            x_q      <= '0;
            aen_q    <= AEN_RST;
            dp_en_q  <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            dp_lat_q <= dp_lat_d;
            x_q      <= x_d;
            aen_q    <= aen_d;
            dp_en_q  <= dp_en_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign x        = x_q;
    assign aen      = aen_q;
    assign dp_en    = dp_en_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_seg7_bin2bcd.sv
// Directed-vector bench for seg7_bin2bcd (default BIN_W=32); honours SEG7_LZB_EN for aen expectations.
module tb_seg7_bin2bcd;

    logic        clk;
    logic        clr;
    logic        start;
    logic [31:0] bin;
    logic [7:0]  dp_in;
    logic        busy;
    logic        done;
    logic [31:0] x;
    logic [7:0]  aen;
    logic [7:0]  dp_en;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    seg7_bin2bcd #(.BIN_W(32)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .bin      (bin),
        .dp_in    (dp_in),
        .busy     (busy),
        .done     (done),
        .x        (x),
        .aen      (aen),
        .dp_en    (dp_en),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SEG7_LZB_EN
    localparam logic [7:0] AEN_RST = 8'h01;
`else
    localparam logic [7:0] AEN_RST = 8'hFF;
`endif

    function automatic logic [7:0] exp_aen(input logic [7:0] lzb);
`ifdef SEG7_LZB_EN
        return lzb;
`else
        return 8'hFF;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, expv);
        end
    endtask

    task automatic run_conv(input logic [31:0] b, input logic [7:0] dp, input logic [31:0] ex,
                            input logic [7:0] ea_lzb, input logic eo);
        int n;
        bit got_done;
        @(negedge clk);
        start = 1'b1; bin = b; dp_in = dp;
        @(posedge clk); #1;
        chk("busy_after_accept", 32'(busy), 32'd1);
        start = 1'b0; bin = ~b; dp_in = ~dp;
        n = 0; got_done = 1'b0;
        while (!got_done && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (done) got_done = 1'b1;
        end
        chk("latency", 32'(n), 32'd33);
        chk("x", x, ex);
        chk("aen", 32'(aen), 32'(exp_aen(ea_lzb)));
        chk("dp_en", 32'(dp_en), 32'(dp));
        chk("overflow", 32'(overflow), 32'(eo));
        chk("busy_on_done", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("x_hold", x, ex);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int ndone;
        int n;
        int drops;
        bit got_done;
        logic [31:0] vals [3];
        logic [31:0] exps [3];

        clr = 1'b1; start = 1'b0; bin = '0; dp_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_x", x, 32'h0);
        chk("rst_aen", 32'(aen), 32'(AEN_RST));
        chk("rst_dp_en", 32'(dp_en), 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        // Abort a conversion with clr during SHIFT; it must never report done.
        @(negedge clk);
        clr = 1'b0; start = 1'b1; bin = 32'd5; dp_in = 8'hAA;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        clr = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        clr = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        chk("abort_x_reset", x, 32'h0);

        run_conv(32'd12345678,  8'h04, 32'h1234_5678, 8'hFF, 1'b0);
        run_conv(32'd0,         8'h00, 32'h0000_0000, 8'h01, 1'b0);
        run_conv(32'd1000,      8'h10, 32'h0000_1000, 8'h0F, 1'b0);
        run_conv(32'd7,         8'h80, 32'h0000_0007, 8'h01, 1'b0);
        run_conv(32'd65535,     8'h01, 32'h0006_5535, 8'h1F, 1'b0);
        run_conv(32'd99999999,  8'h00, 32'h9999_9999, 8'hFF, 1'b0);
        run_conv(32'd100000000, 8'h02, 32'h9999_9999, 8'hFF, 1'b1);
        run_conv(32'hFFFF_FFFF, 8'hFF, 32'h9999_9999, 8'hFF, 1'b1);

        // start held high: each accept samples bin on the edge ending the done cycle.
        vals[0] = 32'd42;       exps[0] = 32'h0000_0042;
        vals[1] = 32'd2023;     exps[1] = 32'h0000_2023;
        vals[2] = 32'd31415926; exps[2] = 32'h3141_5926;
        drops = 0;
        @(negedge clk);
        start = 1'b1; bin = vals[0]; dp_in = 8'h00;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("b2b_accept_busy", 32'(busy), 32'd1);
            bin = $urandom;
            n = 0; got_done = 1'b0;
            while (!got_done && n < 40) begin
                @(posedge clk); #1;
                n++;
                if (done) got_done = 1'b1;
                else if (!busy) drops++;
                if (n == 10) bin = $urandom;
            end
            chk("b2b_latency", 32'(n), 32'd33);
            chk("b2b_x", x, exps[k]);
            if (k < 2) bin = vals[k+1];
            else       start = 1'b0;
        end
        chk("b2b_busy_drops", 32'(drops), 32'd0);
        @(posedge clk); #1;
        chk("b2b_idle_after_stop", 32'(busy), 32'd0);

        // clr and start together: clr wins.
        @(negedge clk);
        clr = 1'b1; start = 1'b1; bin = 32'd5;
        @(posedge clk); #1;
        chk("clr_wins_busy", 32'(busy), 32'd0);
        chk("clr_wins_x", x, 32'h0);
        chk("clr_wins_aen", 32'(aen), 32'(AEN_RST));
        clr = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
